if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the IF_ID register and the decode stage, and supplies pc, instruction and prediction to them. It fetches from a byte-wide memory port through an optional direct-mapped instruction cache. It predicts next-pc using a 2-bit branch history table (BHT) and static JAL handling, and accepts redirects from EX.

---
 rtl/if_fetch.sv | 184 ++++++++++++++++++
 tb/tb_if_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: RV32I instruction-fetch stage.
// Fetches 32-bit words over a byte-wide memory port, predicts the next pc
// (static JAL, 2-bit BHT for conditional branches) and accepts EX redirects.
// Optional direct-mapped I-cache (one word per line) enabled by `ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          ICACHE_INDEX_W = 6,
  parameter int          BHT_INDEX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        bht_upd,
  input  logic [31:0] bht_upd_pc,
  input  logic        bht_upd_taken,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [7:0]  mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_prediction
);

  typedef enum logic [2:0] {LOOKUP, BYTE0, BYTE1, BYTE2, BYTE3} state_t;

  localparam int BHT_N = 1 << BHT_INDEX_W;

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [23:0] byte_buf;
  logic [1:0]  bht [0:BHT_N-1];

  logic        hold;
  logic        hit;
  logic [31:0] hit_word;
  logic        fill_done;
  logic        deliver;
  logic [31:0] new_word;
  logic [31:0] next_pc;
  logic        pred;
  logic [31:0] j_imm, b_imm;
  logic [BHT_INDEX_W-1:0] bht_rd_idx, bht_wr_idx;
  logic        unused_bits;

  assign hold       = if_valid && stall_in;
  assign fill_done  = (state == BYTE3) && mem_valid;
  assign deliver    = ((state == LOOKUP) && !hold && hit) || fill_done;
  assign new_word   = fill_done ? {mem_rdata, byte_buf} : hit_word;
  assign bht_rd_idx = pc[BHT_INDEX_W+1:2];
  assign bht_wr_idx = bht_upd_pc[BHT_INDEX_W+1:2];
  assign unused_bits = ^{bht_upd_pc[31:BHT_INDEX_W+2], bht_upd_pc[1:0]};

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_INDEX_W;
  localparam int TAG_W = 30 - ICACHE_INDEX_W;

  logic [TAG_W-1:0]          tag_q  [0:LINES-1];
  logic [31:0]               data_q [0:LINES-1];
  logic [LINES-1:0]          line_vld;
  logic [ICACHE_INDEX_W-1:0] idx;

  assign idx      = pc[ICACHE_INDEX_W+1:2];
  assign hit      = line_vld[idx] && (tag_q[idx] == pc[31:ICACHE_INDEX_W+2]);
  assign hit_word = data_q[idx];

  // Line valid bits; a completed fill is written even if a redirect drops it.
  always_ff @(posedge clk) begin
    if (!rst) line_vld <= '0;
    else if (fill_done) line_vld[idx] <= 1'b1;
  end

  // Tag/data storage needs no reset: guarded by line_vld.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[idx]  <= pc[31:ICACHE_INDEX_W+2];
      data_q[idx] <= {mem_rdata, byte_buf};
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  // Next-pc prediction on the word being delivered this cycle.
  always_comb begin
    j_imm   = {{11{new_word[31]}}, new_word[31], new_word[19:12], new_word[20],
               new_word[30:21], 1'b0};
    b_imm   = {{19{new_word[31]}}, new_word[31], new_word[7], new_word[30:25],
               new_word[11:8], 1'b0};
    next_pc = pc + 32'd4;
    pred    = 1'b0;
    if (new_word[6:0] == 7'b1101111) begin
      next_pc = pc + j_imm;
      pred    = 1'b1;
    end else if (new_word[6:0] == 7'b1100011 && bht[bht_rd_idx][1]) begin
      next_pc = pc + b_imm;
      pred    = 1'b1;
    end
  end

  // FSM next state and memory request; redirect always returns to LOOKUP.
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_addr = '0;
    case (state)
      LOOKUP: if (!hold && !hit) state_nx = BYTE0;
      BYTE0: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_valid) state_nx = BYTE1;
      end
      BYTE1: begin
        mem_req  = 1'b1;
        mem_addr = pc + 32'd1;
        if (mem_valid) state_nx = BYTE2;
      end
      BYTE2: begin
        mem_req  = 1'b1;
        mem_addr = pc + 32'd2;
        if (mem_valid) state_nx = BYTE3;
      end
      BYTE3: begin
        mem_req  = 1'b1;
        mem_addr = pc + 32'd3;
        if (mem_valid) state_nx = LOOKUP;
      end
      default: state_nx = LOOKUP;
    endcase
    if (br_redirect) state_nx = LOOKUP;
  end

  // State, pc, byte assembly and IF_ID payload registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= LOOKUP;
      pc             <= RESET_PC;
      byte_buf       <= '0;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_instruction <= '0;
      if_prediction  <= 1'b0;
    end else begin
      state <= state_nx;
      if (br_redirect) begin
        pc       <= br_target;
        if_valid <= 1'b0;
      end else if (deliver) begin
        pc             <= next_pc;
        if_valid       <= 1'b1;
        if_pc          <= pc;
        if_instruction <= new_word;
        if_prediction  <= pred;
      end else if (if_valid && !stall_in) begin
        if_valid <= 1'b0;
      end
      if (mem_valid && !br_redirect) begin
        case (state)
          BYTE0:   byte_buf[7:0]   <= mem_rdata;
          BYTE1:   byte_buf[15:8]  <= mem_rdata;
          BYTE2:   byte_buf[23:16] <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  // Saturating 2-bit branch history counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (bht_upd) begin
      if (bht_upd_taken && bht[bht_wr_idx] != 2'b11)
        bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'b01;
      else if (!bht_upd_taken && bht[bht_wr_idx] != 2'b00)
        bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'b01;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a zero-wait byte memory.
// A table of {instruction at pc, expected pc/prediction} is walked twice
// (second lap exercises I-cache hits when ICACHE_EN is defined), followed by
// hand sequences for BHT training, redirect mid-fill and output stall.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b0;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = '0;
  logic        bht_upd = 1'b0;
  logic [31:0] bht_upd_pc = '0;
  logic        bht_upd_taken = 1'b0;
  logic        mem_req, mem_valid;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        if_valid, if_prediction;
  logic [31:0] if_pc, if_instruction;

  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  int cyc = 0;
  logic [31:0] addr_q [$];
  logic [7:0]  mem [0:1023];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        pred;
  } vec_t;

  vec_t lap [8];

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .br_redirect(br_redirect), .br_target(br_target),
    .bht_upd(bht_upd), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
    .if_prediction(if_prediction)
  );

  // Byte memory answers every request in the same cycle.
  always_comb begin
    mem_valid = mem_req;
    mem_rdata = mem[mem_addr[9:0]];
  end

  // Record memory handshakes (sampled mid-cycle).
  always @(negedge clk) begin
    if (mem_req && mem_valid) begin
      hs_cnt <= hs_cnt + 1;
      addr_q.push_back(mem_addr);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic putw(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:0]]         = w[7:0];
    mem[a[9:0] + 10'd1] = w[15:8];
    mem[a[9:0] + 10'd2] = w[23:16];
    mem[a[9:0] + 10'd3] = w[31:24];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the next delivered word and compare {pred, pc, instr}.
  task automatic wait_word(input string name, input logic [31:0] p,
                           input logic [31:0] ins, input logic pr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 60);
    if (!if_valid) begin
      vecs++;
      errs++;
      $display("FAIL %s: no if_valid within 60 cycles, expected pc %h", name, p);
    end else begin
      chk(name, 128'({if_prediction, if_pc, if_instruction}), 128'({pr, p, ins}));
    end
  endtask

  task automatic bht_train(input logic [31:0] p, input logic t);
    bht_upd = 1'b1;
    bht_upd_pc = p;
    bht_upd_taken = t;
    @(negedge clk);
    bht_upd = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    br_redirect = 1'b1;
    br_target = t;
    @(negedge clk);
    br_redirect = 1'b0;
  endtask

  initial begin
    int t0, h0, n;
    lap = '{
      '{32'h00, 32'h00100093, 1'b0},
      '{32'h04, 32'h00200113, 1'b0},
      '{32'h08, 32'h00300193, 1'b0},
      '{32'h0C, 32'h00400213, 1'b0},
      '{32'h10, 32'h0080006F, 1'b1},   // jal +8 -> 0x18
      '{32'h18, 32'h0080006F, 1'b1},   // jal +8 -> 0x20
      '{32'h20, 32'h00000463, 1'b0},   // beq +8, BHT weakly not-taken
      '{32'h24, 32'hFDDFF06F, 1'b1}    // jal -36 -> 0x0
    };
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) putw(lap[i].pc, lap[i].ins);
    putw(32'h14,  32'h00000013);
    putw(32'h28,  32'h00500293);
    putw(32'h2C,  32'h0000006F);
    putw(32'h40,  32'h00600313);
    putw(32'h100, 32'h00700393);
    putw(32'h104, 32'h00800413);
    putw(32'h108, 32'h00900493);
    putw(32'h10C, 32'h0000006F);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        128'({mem_req, mem_addr, if_valid, if_pc, if_instruction, if_prediction}), 128'(0));
    rst = 1'b1;

    // Lap 1: cold fetches; first fill must request bytes 0..3.
    for (int i = 0; i < 8; i++) begin
      wait_word($sformatf("lap1_pc_%0h", lap[i].pc), lap[i].pc, lap[i].ins, lap[i].pred);
      if (i == 0) begin
        chk("first_fill_count", 128'(addr_q.size()), 128'(4));
        if (addr_q.size() == 4)
          chk("first_fill_addrs", 128'({addr_q[0], addr_q[1], addr_q[2], addr_q[3]}),
              128'({32'd0, 32'd1, 32'd2, 32'd3}));
      end
    end

    // Lap 2: same stream; cache hits deliver one word per cycle with no reads.
    t0 = cyc;
    h0 = hs_cnt;
    for (int i = 0; i < 8; i++)
      wait_word($sformatf("lap2_pc_%0h", lap[i].pc), lap[i].pc, lap[i].ins, lap[i].pred);
`ifdef ICACHE_EN
    chk("lap2_cycles", 128'(cyc - t0), 128'(8));
    chk("lap2_mem_reads", 128'(hs_cnt - h0), 128'(0));
`else
    chk("lap2_cycles", 128'(cyc - t0), 128'(40));
    chk("lap2_mem_reads", 128'(hs_cnt - h0), 128'(32));
`endif

    // BHT: three taken updates saturate to 11 -> beq predicted taken.
    bht_train(32'h20, 1'b1);
    bht_train(32'h20, 1'b1);
    bht_train(32'h20, 1'b1);
    redirect(32'h20);
    wait_word("bht_taken_beq", 32'h20, 32'h00000463, 1'b1);
    wait_word("bht_taken_target", 32'h28, 32'h00500293, 1'b0);
    wait_word("jal_self", 32'h2C, 32'h0000006F, 1'b1);
    // One not-taken: 11 -> 10, still taken.
    bht_train(32'h20, 1'b0);
    redirect(32'h20);
    wait_word("bht_10_beq", 32'h20, 32'h00000463, 1'b1);
    wait_word("bht_10_target", 32'h28, 32'h00500293, 1'b0);
    // Another not-taken: 10 -> 01, falls through.
    bht_train(32'h20, 1'b0);
    redirect(32'h20);
    wait_word("bht_01_beq", 32'h20, 32'h00000463, 1'b0);
    wait_word("bht_01_fallthru", 32'h24, 32'hFDDFF06F, 1'b1);

    // Redirect while fetching byte 2 of 0x40.
    redirect(32'h40);
    n = 0;
    while (!(mem_req && mem_addr == 32'h42) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(mem_req && mem_addr == 32'h42)) begin
      vecs++;
      errs++;
      $display("FAIL byte2_wait: mem_addr 0x42 never requested, last %h", mem_addr);
    end else begin
      br_redirect = 1'b1;
      br_target = 32'h100;
      @(negedge clk);
      br_redirect = 1'b0;
      chk("redirect_kills_req", 128'({mem_req, if_valid}), 128'(0));
    end
    wait_word("refetch_0x100", 32'h100, 32'h00700393, 1'b0);

    // Stall for 3 cycles with a valid word held.
    stall_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", k), 128'({if_valid, if_pc, if_instruction, mem_req}),
          128'({1'b1, 32'h100, 32'h00700393, 1'b0}));
    end
    stall_in = 1'b0;
    wait_word("after_stall_0x104", 32'h104, 32'h00800413, 1'b0);
    wait_word("after_stall_0x108", 32'h108, 32'h00900493, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
